// File: rtl/timer0_counter.sv
// Timer/Counter 0 datapath for the 8051: TL0/TH0 storage, mode 0-3 counting,
// SFR write/read-back and one-cycle TF0/TF1 set requests toward TCON.
module timer0_counter #(
  parameter logic [7:0] SFR_TL0 = 8'h8A,
  parameter logic [7:0] SFR_TH0 = 8'h8C
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic [7:0] addr,
  input  logic       wr_en,
  input  logic       wr_bit_en,
  input  logic       rd_en,
  input  logic       cycle_tick,
  input  logic [3:0] tmod0,
  input  logic       tr0,
  input  logic       tr1,
  input  logic       int0_n,
  input  logic       t0_pin,
  output logic [7:0] data_out,
  output logic       rd_hit,
  output logic [7:0] tl0,
  output logic [7:0] th0,
  output logic       tf0_set,
  output logic       tf1_set
);

  logic       r_t0_s1;
  logic       r_t0_s2;
  logic       r_t0_prev;
  logic [7:0] r_tl0;
  logic [7:0] r_th0;
  logic       r_tf0_set;
  logic       r_tf1_set;

  logic       w_gate;
  logic       w_ct;
  logic [1:0] w_mode;
  logic       w_t0_fall;
  logic       w_run0;
  logic       w_inc;
  logic       w_tick1;
  logic       w_wr_tl;
  logic       w_wr_th;
  logic [7:0] w_tl0_cnt;
  logic [7:0] w_th0_cnt;
  logic       w_ovf0;
  logic       w_ovf1;
  logic [7:0] w_tl0_nxt;
  logic [7:0] w_th0_nxt;
  logic       w_tf0_nxt;
  logic       w_tf1_nxt;

  assign w_gate    = tmod0[3];
  assign w_ct      = tmod0[2];
  assign w_mode    = tmod0[1:0];
  assign w_t0_fall = r_t0_prev & ~r_t0_s2;
  assign w_run0    = tr0 & (~w_gate | int0_n);
  assign w_inc     = w_run0 & (w_ct ? w_t0_fall : cycle_tick);
  assign w_tick1   = cycle_tick & tr1;
  assign w_wr_tl   = wr_en & ~wr_bit_en & (addr == SFR_TL0);
  assign w_wr_th   = wr_en & ~wr_bit_en & (addr == SFR_TH0);

  // T0 pin synchronizer; idles high so reset release never fakes a falling edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_t0_s1   <= 1'b1;
      r_t0_s2   <= 1'b1;
      r_t0_prev <= 1'b1;
    end else begin
      r_t0_s1   <= t0_pin;
      r_t0_s2   <= r_t0_s1;
      r_t0_prev <= r_t0_s2;
    end
  end

  always_comb begin
    w_tl0_cnt = r_tl0;
    w_th0_cnt = r_th0;
    w_ovf0    = 1'b0;
    w_ovf1    = 1'b0;
    case (w_mode)
      2'b00: begin
        if (w_inc && (r_tl0[4:0] == 5'h1F)) begin
          w_tl0_cnt = {r_tl0[7:5], 5'h00};
          w_th0_cnt = r_th0 + 8'h01;
          w_ovf0    = (r_th0 == 8'hFF);
        end else if (w_inc) begin
          w_tl0_cnt = {r_tl0[7:5], r_tl0[4:0] + 5'h01};
        end else begin
          w_tl0_cnt = r_tl0;
        end
      end
      2'b01: begin
        if (w_inc) begin
          {w_th0_cnt, w_tl0_cnt} = {r_th0, r_tl0} + 16'h0001;
          w_ovf0 = ({r_th0, r_tl0} == 16'hFFFF);
        end else begin
          w_tl0_cnt = r_tl0;
        end
      end
      2'b10: begin
        // auto-reload: TH0 is only a reload source here
        if (w_inc && (r_tl0 == 8'hFF)) begin
          w_tl0_cnt = r_th0;
          w_ovf0    = 1'b1;
        end else if (w_inc) begin
          w_tl0_cnt = r_tl0 + 8'h01;
        end else begin
          w_tl0_cnt = r_tl0;
        end
      end
      2'b11: begin
        if (w_inc) begin
          w_tl0_cnt = r_tl0 + 8'h01;
          w_ovf0    = (r_tl0 == 8'hFF);
        end else begin
          w_tl0_cnt = r_tl0;
        end
        if (w_tick1) begin
          w_th0_cnt = r_th0 + 8'h01;
          w_ovf1    = (r_th0 == 8'hFF);
        end else begin
          w_th0_cnt = r_th0;
        end
      end
      default: begin
        w_tl0_cnt = r_tl0;
        w_th0_cnt = r_th0;
      end
    endcase
  end

  // A written byte takes data_in and drops any overflow it would have produced
  assign w_tl0_nxt = w_wr_tl ? data_in : w_tl0_cnt;
  assign w_th0_nxt = w_wr_th ? data_in : w_th0_cnt;
  assign w_tf0_nxt = w_ovf0 & ~(w_mode[1] ? w_wr_tl : w_wr_th);
  assign w_tf1_nxt = w_ovf1 & ~w_wr_th;

  // Counter bytes and registered overflow pulses
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tl0     <= 8'h00;
      r_th0     <= 8'h00;
      r_tf0_set <= 1'b0;
      r_tf1_set <= 1'b0;
    end else begin
      r_tl0     <= w_tl0_nxt;
      r_th0     <= w_th0_nxt;
      r_tf0_set <= w_tf0_nxt;
      r_tf1_set <= w_tf1_nxt;
    end
  end

  assign rd_hit = rd_en & ((addr == SFR_TL0) | (addr == SFR_TH0));

  // Read mux returns pre-increment values
  always_comb begin
    data_out = 8'h00;
    if (rd_hit && (addr == SFR_TL0)) begin
      data_out = r_tl0;
    end else if (rd_hit) begin
      data_out = r_th0;
    end else begin
      data_out = 8'h00;
    end
  end

  assign tl0     = r_tl0;
  assign th0     = r_th0;
  assign tf0_set = r_tf0_set;
  assign tf1_set = r_tf1_set;

endmodule

// File: tb/tb_timer0_counter.sv
// Self-checking bench for timer0_counter: directed scenarios followed by random
// traffic, all compared against an arithmetic reference model of TL0/TH0.
module tb_timer0_counter;
  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic [7:0] addr;
  logic       wr_en;
  logic       wr_bit_en;
  logic       rd_en;
  logic       cycle_tick;
  logic [3:0] tmod0;
  logic       tr0;
  logic       tr1;
  logic       int0_n;
  logic       t0_pin;
  logic [7:0] data_out;
  logic       rd_hit;
  logic [7:0] tl0;
  logic [7:0] th0;
  logic       tf0_set;
  logic       tf1_set;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  int m_tl = 0;
  int m_th = 0;
  bit m_tf0 = 1'b0;
  bit m_tf1 = 1'b0;
  bit p1 = 1'b1, p2 = 1'b1, p3 = 1'b1;  // pin samples at the last three edges

  timer0_counter dut (
    .clock(clock), .reset(reset), .data_in(data_in), .addr(addr),
    .wr_en(wr_en), .wr_bit_en(wr_bit_en), .rd_en(rd_en),
    .cycle_tick(cycle_tick), .tmod0(tmod0), .tr0(tr0), .tr1(tr1),
    .int0_n(int0_n), .t0_pin(t0_pin), .data_out(data_out), .rd_hit(rd_hit),
    .tl0(tl0), .th0(th0), .tf0_set(tf0_set), .tf1_set(tf1_set)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check the read path, advance the model, compare after the edge.
  task automatic cycle();
    bit         inc, fall, wtl, wth, o0, o1, hit;
    int         mode, c, ntl, nth;
    logic [15:0] exp_rd;
    #1;
    hit    = rd_en && (addr == 8'h8A || addr == 8'h8C);
    exp_rd = !hit ? 16'h0000 : (addr == 8'h8A) ? 16'(m_tl) : 16'(m_th);
    chk("rd_hit", 16'(rd_hit), 16'(hit));
    chk("data_out", 16'(data_out), exp_rd);

    mode = int'(tmod0[1:0]);
    fall = p3 && !p2;
    inc  = tr0 && (!tmod0[3] || int0_n) && (tmod0[2] ? fall : cycle_tick);
    wtl  = wr_en && !wr_bit_en && addr == 8'h8A;
    wth  = wr_en && !wr_bit_en && addr == 8'h8C;
    ntl  = m_tl;
    nth  = m_th;
    o0   = 1'b0;
    o1   = 1'b0;
    case (mode)
      0: begin
        c = m_th * 32 + m_tl % 32 + int'(inc);
        if (c == 8192) begin o0 = 1'b1; c = 0; end
        ntl = (m_tl / 32) * 32 + c % 32;
        nth = c / 32;
      end
      1: begin
        c = m_th * 256 + m_tl + int'(inc);
        if (c == 65536) begin o0 = 1'b1; c = 0; end
        ntl = c % 256;
        nth = c / 256;
      end
      2: begin
        if (inc && m_tl == 255) begin ntl = m_th; o0 = 1'b1; end
        else ntl = m_tl + int'(inc);
      end
      default: begin
        ntl = m_tl + int'(inc);
        if (ntl == 256) begin ntl = 0; o0 = 1'b1; end
        nth = m_th + int'(cycle_tick && tr1);
        if (nth == 256) begin nth = 0; o1 = 1'b1; end
      end
    endcase
    if (wtl) begin ntl = int'(data_in); if (mode >= 2) o0 = 1'b0; end
    if (wth) begin nth = int'(data_in); if (mode < 2) o0 = 1'b0; o1 = 1'b0; end
    m_tl = ntl; m_th = nth; m_tf0 = o0; m_tf1 = o1;
    p3 = p2; p2 = p1; p1 = t0_pin;

    @(posedge clock);
    #1;
    chk("tl0", 16'(tl0), 16'(m_tl));
    chk("th0", 16'(th0), 16'(m_th));
    chk("tf0_set", 16'(tf0_set), 16'(m_tf0));
    chk("tf1_set", 16'(tf1_set), 16'(m_tf1));
    @(negedge clock);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; data_in = d; wr_en = 1'b1; wr_bit_en = 1'b0;
    cycle();
    wr_en = 1'b0; addr = 8'h00;
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_tl0", 16'(tl0), 16'h0000);
    chk("rst_th0", 16'(th0), 16'h0000);
    chk("rst_tf0", 16'(tf0_set), 16'h0000);
    chk("rst_tf1", 16'(tf1_set), 16'h0000);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    m_tl = 0; m_th = 0; m_tf0 = 1'b0; m_tf1 = 1'b0;
    p1 = 1'b1; p2 = 1'b1; p3 = 1'b1;
  endtask

  initial begin
    reset = 1'b1; data_in = 8'h00; addr = 8'h00; wr_en = 1'b0; wr_bit_en = 1'b0;
    rd_en = 1'b0; cycle_tick = 1'b0; tmod0 = 4'h0; tr0 = 1'b0; tr1 = 1'b0;
    int0_n = 1'b1; t0_pin = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // reset values and read-back
    rd_en = 1'b1;
    addr = 8'h8A; #1 chk("rd_tl0_hit", 16'(rd_hit), 16'h0001); chk("rd_tl0_val", 16'(data_out), 16'h0000);
    cycle();
    addr = 8'h8C; #1 chk("rd_th0_hit", 16'(rd_hit), 16'h0001); chk("rd_th0_val", 16'(data_out), 16'h0000);
    cycle();
    addr = 8'h88; #1 chk("rd_88_hit", 16'(rd_hit), 16'h0000); chk("rd_88_val", 16'(data_out), 16'h0000);
    cycle();
    rd_en = 1'b0;

    // mode 1 16-bit wrap
    tmod0 = 4'b0001;
    wr(8'h8C, 8'hFF); wr(8'h8A, 8'hFE);
    tr0 = 1'b1; cycle_tick = 1'b1;
    cycle(); chk("m1_tl_ff", 16'(tl0), 16'h00FF); chk("m1_no_tf", 16'(tf0_set), 16'h0000);
    cycle(); chk("m1_wrap", {th0, tl0}, 16'h0000); chk("m1_tf", 16'(tf0_set), 16'h0001);
    tr0 = 1'b0;
    cycle(); chk("m1_tf_once", 16'(tf0_set), 16'h0000);

    // mode 2 auto-reload, two overflows
    tmod0 = 4'b0010;
    wr(8'h8C, 8'hF0); wr(8'h8A, 8'hFD);
    tr0 = 1'b1;
    repeat (3) cycle();
    chk("m2_reload", 16'(tl0), 16'h00F0); chk("m2_tf", 16'(tf0_set), 16'h0001);
    begin
      int pulses = 0;
      for (int i = 0; i < 16; i++) begin
        cycle();
        pulses += int'(tf0_set);
      end
      chk("m2_pulses", 16'(pulses), 16'h0001);
      chk("m2_last_tf", 16'(tf0_set), 16'h0001);
    end
    chk("m2_th_kept", 16'(th0), 16'h00F0);
    tr0 = 1'b0;

    // mode 0 prescaler carry into TH0
    tmod0 = 4'b0000;
    wr(8'h8C, 8'hFF); wr(8'h8A, 8'hBE);
    tr0 = 1'b1;
    cycle(); chk("m0_tl_bf", 16'(tl0), 16'h00BF);
    cycle(); chk("m0_wrap", {th0, tl0}, 16'h00A0); chk("m0_tf", 16'(tf0_set), 16'h0001);
    tr0 = 1'b0;

    // counter mode, gated by INT0
    tmod0 = 4'b1101; cycle_tick = 1'b0;
    wr(8'h8A, 8'h00); wr(8'h8C, 8'h00);
    tr0 = 1'b1; int0_n = 1'b0;
    repeat (5) begin
      t0_pin = 1'b0; cycle(); cycle();
      t0_pin = 1'b1; cycle(); cycle();
    end
    repeat (3) cycle();
    chk("gate_blocks", 16'(tl0), 16'h0000);
    int0_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t0_pin = 1'b0;
      cycle(); cycle();
      chk("t0_latency_hold", 16'(tl0), 16'(i));
      cycle();
      chk("t0_count", 16'(tl0), 16'(i + 1));
      t0_pin = 1'b1;
      cycle();
    end
    chk("t0_total", 16'(tl0), 16'h0003);
    tr0 = 1'b0;

    // mode 3 split, TH0 on tr1
    tmod0 = 4'b0011; tr1 = 1'b1;
    wr(8'h8C, 8'hFE); wr(8'h8A, 8'h42);
    cycle_tick = 1'b1;
    cycle(); cycle();
    chk("m3_th_wrap", 16'(th0), 16'h0000); chk("m3_tf1", 16'(tf1_set), 16'h0001);
    chk("m3_tf0", 16'(tf0_set), 16'h0000); chk("m3_tl_frozen", 16'(tl0), 16'h0042);
    tr1 = 1'b0;

    // write collides with a tick
    tmod0 = 4'b0001;
    wr(8'h8A, 8'h10); wr(8'h8C, 8'h20);
    tr0 = 1'b1;
    addr = 8'h8A; data_in = 8'h55; wr_en = 1'b1;
    cycle();
    wr_en = 1'b0; addr = 8'h00;
    chk("wr_wins_tl", 16'(tl0), 16'h0055); chk("wr_th_kept", 16'(th0), 16'h0020);

    // reset while running, no pulse after release
    wr(8'h8A, 8'hFF); wr(8'h8C, 8'hFF);
    do_reset();
    cycle(); chk("rst_no_tf", 16'(tf0_set), 16'h0000);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) tmod0 = 4'($urandom_range(0, 15));
      cycle_tick = 1'($urandom_range(0, 1));
      tr0        = ($urandom_range(0, 3) != 0);
      tr1        = 1'($urandom_range(0, 1));
      int0_n     = ($urandom_range(0, 3) != 0);
      t0_pin     = 1'($urandom_range(0, 1));
      rd_en      = 1'($urandom_range(0, 1));
      wr_en      = ($urandom_range(0, 7) == 0);
      wr_bit_en  = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: addr = 8'h8A;
        1: addr = 8'h8C;
        2: addr = 8'h88;
        default: addr = 8'($urandom_range(0, 255));
      endcase
      data_in = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 255));
      if (i == 700) do_reset();
      else cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
